// File: rtl/nibble_serial_addsub_ctrl.sv
// rtl/nibble_serial_addsub_ctrl.sv - wide add/sub sequenced one nibble per clock through a 4-bit slice
// Optional abort input is enabled by defining ABORT_EN.
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   overflow
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  wa, wb, wres;
    logic          wop;
    logic          creg;
    logic [IW-1:0] idx;

    logic [3:0]    an, bn, sn;
    logic          cout;
    logic          last;
    logic          accept;
    logic          abort_req;

`ifdef ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The single 4-bit slice: B is inverted for subtract, carry-in preloaded with op.
    always_comb begin
        an = wa[4*idx +: 4];
        bn = wb[4*idx +: 4] ^ {4{wop}};
        {cout, sn} = {1'b0, an} + {1'b0, bn} + {4'b0000, creg};
    end

    assign last   = (idx == LAST_IDX);
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                if (abort_req)  state_nx = IDLE;
                else if (last)  state_nx = DONE;
            end
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wa       <= '0;
            wb       <= '0;
            wres     <= '0;
            wop      <= 1'b0;
            creg     <= 1'b0;
            idx      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            wa   <= a;
            wb   <= b;
            wop  <= op;
            creg <= op;
            idx  <= '0;
        end else if ((state == RUN) && !abort_req) begin
            wres[4*idx +: 4] <= sn;
            creg             <= cout;
            idx              <= idx + IW'(1);
            if (last) begin
                // Top nibble is still in flight, so splice it in directly.
                result   <= {sn, wres[W-5:0]};
                carry    <= cout ^ wop;
                overflow <= an[3] ^ bn[3] ^ sn[3] ^ cout;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// tb/tb_nibble_serial_addsub_ctrl.sv - scoreboard bench for nibble_serial_addsub_ctrl
module tb_nibble_serial_addsub_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
`ifdef ABORT_EN
    logic         abort;
`endif
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done, carry, overflow;
    logic [W-1:0] result;

    nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef ABORT_EN
        .abort    (abort),
`endif
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           k;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: whole-word arithmetic and sign rules, no nibble stepping.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xop);
        exp_t       e;
        logic [W:0] full;
        if (xop) full = {1'b0, xa} - {1'b0, xb};
        else     full = {1'b0, xa} + {1'b0, xb};
        e.r = full[W-1:0];
        e.c = full[W];
        if (xop) e.v = (xa[W-1] != xb[W-1]) && (e.r[W-1] != xa[W-1]);
        else     e.v = (xa[W-1] == xb[W-1]) && (e.r[W-1] != xa[W-1]);
        e.k = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation (result %h)", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result",   result,            e.r);
                chk("carry",    W'(carry),         W'(e.c));
                chk("overflow", W'(overflow),      W'(e.v));
                chk("latency",  W'(edge_cnt - e.k), W'(N));
            end
        end
    end

    // Waits for an accepting state, presents one request, returns #1 after the accept edge.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xop, input bit push);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", W'(busy), W'(0));
        a     = xa;
        b     = xb;
        op    = xop;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e   = model(xa, xb, xop);
            e.k = edge_cnt;
            q.push_back(e);
        end
        a  = W'($urandom);
        b  = W'($urandom);
        op = 1'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", W'(q.size()), W'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
`ifdef ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",     W'(busy),     W'(0));
        chk("reset_done",     W'(done),     W'(0));
        chk("reset_result",   result,       W'(0));
        chk("reset_carry",    W'(carry),    W'(0));
        chk("reset_overflow", W'(overflow), W'(0));

        issue(16'h1234, 16'h4321, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("busy_run", W'(busy), W'(1));
        end
        @(negedge clk);
        chk("busy_done", W'(busy), W'(0));
        chk("done_level", W'(done), W'(1));
        drain();

        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        issue(16'h0000, 16'h0001, 1'b1, 1'b1);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1);
        drain();

        // Start pulse during RUN with a different operand must be ignored.
        issue(16'h0001, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        a     = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'hABCD;
        drain();

        for (int i = 0; i < 40; i++)
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        drain();

        issue(16'h7FFF, 16'h7FFF, 1'b0, 1'b1);
        drain();
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",     W'(busy),     W'(0));
        chk("midrst_done",     W'(done),     W'(0));
        chk("midrst_result",   result,       W'(0));
        chk("midrst_carry",    W'(carry),    W'(0));
        chk("midrst_overflow", W'(overflow), W'(0));
        repeat (8) @(negedge clk);
        issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
        drain();

`ifdef ABORT_EN
        issue(16'h1234, 16'h4321, 1'b0, 1'b1);
        drain();
        issue(16'h0F0F, 16'h0101, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy",   W'(busy), W'(0));
        chk("abort_done",   W'(done), W'(0));
        chk("abort_result", result,   16'h5555);
        repeat (8) @(negedge clk);
        chk("abort_hold", result, 16'h5555);
`endif

        repeat (4) @(negedge clk);
        chk("queue_empty", W'(q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
